fir_sequencer: RTL

FIR_SEQUENCER -- requirements
Module: fir_sequencer

---
 rtl/fir_sequencer.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/fir_sequencer.sv
// Burst sequencer in front of an external FIR. It feeds the input samples, then
// zero-flushes the tap line, and returns results through a credit-guarded FIFO.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for i_start; a zero-length start only pulses o_done
// FEED  | passing len input samples to the FIR, one ce per transfer
// FLUSH | issuing TAPS-1 zero samples so every input reaches all taps
// DRAIN | waiting until all results are out of the pipe and accepted
module fir_sequencer #(
  parameter int TAPS    = 8,
  parameter int FIR_LAT = 1,
  parameter int DEPTH   = 4,
  parameter int LEN_W   = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic [LEN_W-1:0]    i_len,
  output logic                o_busy,
  input  logic                i_s_valid,
  input  logic signed [11:0]  i_s_data,
  output logic                o_s_ready,
  output logic                o_fir_ce,
  output logic signed [11:0]  o_fir_sample,
  input  logic signed [30:0]  i_fir_result,
  input  logic                i_fir_valid,
  output logic                o_r_valid,
  output logic signed [30:0]  o_r_data,
  output logic                o_r_last,
  input  logic                i_r_ready,
  output logic                o_done,
  output logic                o_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // occupancy width leaves room for fifo_count + inflight without overflow
  localparam int CW = $clog2(DEPTH + 1) + 1;
  localparam int FW = (TAPS > 2) ? $clog2(TAPS - 1) : 1;
  localparam int RW = LEN_W + 1;

  typedef enum logic [1:0] {IDLE, FEED, FLUSH, DRAIN} state_t;

  state_t                    state_q, state_d;
  logic                      done_q, done_d;
  logic [LEN_W-1:0]          len_q;
  logic [LEN_W-1:0]          feed_cnt_q;
  logic [FW-1:0]             flush_cnt_q;
  logic [RW-1:0]             out_cnt_q;
  logic [RW-1:0]             total;
  logic [FIR_LAT-1:0]        ce_pipe_q;
  logic                      delayed;
  logic [CW-1:0]             inflight;
  logic                      credit_ok;
  logic                      xfer;
  logic                      flush_ce;
  logic                      ce;
  logic                      push;
  logic                      pop;
  logic                      mismatch;
  logic                      err_q;
  logic                      accept_start;

  logic signed [30:0]        mem_q [DEPTH];
  logic [AW-1:0]             wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]             count_q;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign total    = {1'b0, len_q} + RW'(TAPS - 1);
  assign delayed  = ce_pipe_q[FIR_LAT-1];
  assign push     = delayed;
  assign pop      = o_r_valid && i_r_ready;
  assign mismatch = delayed != i_fir_valid;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < FIR_LAT; i++) begin
      inflight = inflight + CW'(ce_pipe_q[i]);
    end
  end

  // results already queued plus those still inside the FIR must fit the FIFO
  assign credit_ok    = (count_q + inflight) < CW'(DEPTH);
  assign xfer         = (state_q == FEED) && i_s_valid && credit_ok;
  assign flush_ce     = (state_q == FLUSH) && credit_ok;
  assign ce           = xfer || flush_ce;
  assign accept_start = (state_q == IDLE) && i_start && (i_len != '0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    done_d       = 1'b0;
    o_s_ready    = 1'b0;
    o_fir_ce     = ce;
    o_fir_sample = '0;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          if (i_len != '0) state_d = FEED;
          else             done_d  = 1'b1;
        end
      end
      FEED: begin
        o_s_ready = credit_ok;
        if (xfer) begin
          o_fir_sample = i_s_data;
          if (feed_cnt_q == len_q - LEN_W'(1)) begin
            state_d = (TAPS == 1) ? DRAIN : FLUSH;
          end
        end
      end
      FLUSH: begin
        if (flush_ce && (flush_cnt_q == FW'(TAPS - 2))) state_d = DRAIN;
      end
      DRAIN: begin
        if ((count_q == '0) && (inflight == '0) && (out_cnt_q == total)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      len_q       <= '0;
      feed_cnt_q  <= '0;
      flush_cnt_q <= '0;
      out_cnt_q   <= '0;
      ce_pipe_q   <= '0;
      err_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      if (accept_start) begin
        len_q       <= i_len;
        feed_cnt_q  <= '0;
        flush_cnt_q <= '0;
        out_cnt_q   <= '0;
      end else begin
        if (xfer)     feed_cnt_q  <= feed_cnt_q + 1'b1;
        if (flush_ce) flush_cnt_q <= flush_cnt_q + 1'b1;
        if (pop)      out_cnt_q   <= out_cnt_q + 1'b1;
      end
      ce_pipe_q <= (ce_pipe_q << 1) | FIR_LAT'(ce);
      if (mismatch) err_q <= 1'b1;
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // storage needs no reset: the read port is gated by o_r_valid
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= i_fir_result;
  end

  assign o_busy    = state_q != IDLE;
  assign o_done    = done_q;
  assign o_err     = err_q || mismatch;
  assign o_r_valid = count_q != '0;
  assign o_r_data  = o_r_valid ? mem_q[rd_ptr_q] : '0;
  assign o_r_last  = o_r_valid && (out_cnt_q == total - RW'(1));

endmodule
